// File: rtl/vec_assembler.sv
`default_nettype none
// ============================================================================
// Module   : vec_assembler
// Purpose  : Collects SUB_VECTOR_NO bus-wide beats into one VECTOR_WIDTH
//            fingerprint, pairs it with the popcount delivered on the final
//            beat and emits {vector, count, last} through a 2-entry
//            valid/ready output FIFO.
// Options  : VEC_ASM_PROTO_CHECK_EN - builds the sticky framing checker that
//            drives dn_ProtoErr; otherwise dn_ProtoErr is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module vec_assembler #(
    parameter int VECTOR_WIDTH  = 920,
    parameter int BUS_WIDTH     = 128,
    parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    up_SubVector,
    input  logic                    up_Valid,
    input  logic [CNT_WIDTH-1:0]    up_Cnt,
    input  logic                    up_CntNew,
    input  logic                    up_Last,
    output logic                    up_Ready,
    output logic [VECTOR_WIDTH-1:0] dn_Vector,
    output logic [CNT_WIDTH-1:0]    dn_Cnt,
    output logic                    dn_Last,
    output logic                    dn_Valid,
    input  logic                    dn_Ready,
    output logic                    dn_ProtoErr
);

    // Counter needs at least one bit even for a single-beat vector.
    localparam int c_WC_WIDTH    = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    // Only the non-final beats are stored; the final beat is taken straight off the bus.
    localparam int c_ASM_WIDTH   = (SUB_VECTOR_NO - 1) * BUS_WIDTH;
    localparam int c_TAIL_WIDTH  = VECTOR_WIDTH - c_ASM_WIDTH;
    localparam int c_ENTRY_WIDTH = VECTOR_WIDTH + CNT_WIDTH + 1;
    localparam logic [c_WC_WIDTH-1:0] c_LAST_WORD = c_WC_WIDTH'(SUB_VECTOR_NO - 1);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e                     occ_q, occ_d;
    logic [c_WC_WIDTH-1:0]    word_cntr_q, word_cntr_d;
    logic [c_ASM_WIDTH-1:0]   asm_q, asm_d;
    logic [c_ENTRY_WIDTH-1:0] head_q, head_d;
    logic [c_ENTRY_WIDTH-1:0] tail_q, tail_d;

    logic                     w_up_ready;
    logic                     w_beat_acc;
    logic                     w_final;
    logic                     w_push;
    logic                     w_pop;
    logic [c_ENTRY_WIDTH-1:0] w_new_entry;

    // Handshake decode; a pop frees a slot in the same cycle, hence dn_Ready feeds up_Ready.
    always_comb begin
        w_up_ready  = rst || (occ_q != OCC_FULL) || dn_Ready;
        w_beat_acc  = up_Valid && w_up_ready;
        w_final     = (word_cntr_q == c_LAST_WORD);
        w_push      = w_beat_acc && w_final;
        w_pop       = (occ_q != OCC_EMPTY) && dn_Ready;
        // Bits of the final beat above VECTOR_WIDTH are dropped here.
        w_new_entry = {up_SubVector[c_TAIL_WIDTH-1:0], asm_q, up_Cnt, up_Last};
    end

    // Beat position within the vector; wraps after the final beat.
    always_comb begin
        word_cntr_d = word_cntr_q;
        if (w_beat_acc) begin
            word_cntr_d = w_final ? '0 : word_cntr_q + c_WC_WIDTH'(1);
        end
    end

    // Store each non-final beat in its slot; every vector rewrites all slots.
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < SUB_VECTOR_NO - 1; k++) begin
            if (w_beat_acc && (word_cntr_q == c_WC_WIDTH'(k))) begin
                asm_d[k*BUS_WIDTH +: BUS_WIDTH] = up_SubVector;
            end
        end
    end

    // Two-slot FIFO: head is always the output entry, tail holds the second one.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (w_push) begin
                    head_d = w_new_entry;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({w_push, w_pop})
                    2'b11: head_d = w_new_entry;
                    2'b10: begin
                        tail_d = w_new_entry;
                        occ_d  = OCC_FULL;
                    end
                    2'b01: occ_d = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_FULL: begin
                if (w_pop) begin
                    head_d = tail_q;
                    if (w_push) begin
                        tail_d = w_new_entry;
                    end else begin
                        occ_d = OCC_ONE;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // Control and FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            word_cntr_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            word_cntr_q <= word_cntr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    // Assembly register carries no reset: stale beats are always overwritten.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    assign up_Ready                     = w_up_ready;
    assign dn_Valid                     = (occ_q != OCC_EMPTY);
    assign {dn_Vector, dn_Cnt, dn_Last} = head_q;

`ifdef VEC_ASM_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;

    // Flag a CntNew marker that disagrees with the counter, or Last on a non-final beat.
    always_comb begin
        proto_err_d = proto_err_q;
        if (w_beat_acc && ((up_CntNew != w_final) || (up_Last && !w_final))) begin
            proto_err_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign dn_ProtoErr = proto_err_q;
`else
    // Framing comes from the word counter alone, so the marker is not needed here.
    logic w_unused_cnt_new;
    assign w_unused_cnt_new = up_CntNew;
    assign dn_ProtoErr      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_assembler
// Purpose  : Directed self-checking bench for vec_assembler at 920/128/8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_assembler;

    localparam int VW = 920;
    localparam int BW = 128;
    localparam int NB = 8;
    localparam int CW = 10;
`ifdef VEC_ASM_PROTO_CHECK_EN
    localparam logic PROTO_EN = 1'b1;
`else
    localparam logic PROTO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] up_SubVector;
    logic          up_Valid;
    logic [CW-1:0] up_Cnt;
    logic          up_CntNew;
    logic          up_Last;
    logic          up_Ready;
    logic [VW-1:0] dn_Vector;
    logic [CW-1:0] dn_Cnt;
    logic          dn_Last;
    logic          dn_Valid;
    logic          dn_Ready;
    logic          dn_ProtoErr;

    always #5 clk = ~clk;

    vec_assembler #(
        .VECTOR_WIDTH (VW),
        .BUS_WIDTH    (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .up_SubVector (up_SubVector),
        .up_Valid     (up_Valid),
        .up_Cnt       (up_Cnt),
        .up_CntNew    (up_CntNew),
        .up_Last      (up_Last),
        .up_Ready     (up_Ready),
        .dn_Vector    (dn_Vector),
        .dn_Cnt       (dn_Cnt),
        .dn_Last      (dn_Last),
        .dn_Valid     (dn_Valid),
        .dn_Ready     (dn_Ready),
        .dn_ProtoErr  (dn_ProtoErr)
    );

    typedef struct {
        logic [VW-1:0] vec;
        logic [CW-1:0] cnt;
        logic          last;
        int            cyc;
    } cap_t;

    cap_t cap_q[$];
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record every transfer out of the FIFO, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && dn_Valid && dn_Ready) begin
            cap_t c;
            c.vec  = dn_Vector;
            c.cnt  = dn_Cnt;
            c.last = dn_Last;
            c.cyc  = cyc_cnt;
            cap_q.push_back(c);
        end
    end

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        logic [NB*BW-1:0] g;
        logic [NB*BW-1:0] e;
        g = '0;
        e = '0;
        g[VW-1:0] = got;
        e[VW-1:0] = exp;
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s[%0d]", tag, i), g[i*BW +: BW], e[i*BW +: BW]);
        end
    endtask

    function automatic logic [BW-1:0] beat(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(k);
        return {16{b}};
    endfunction

    function automatic logic [VW-1:0] pattern(input logic [7:0] base);
        logic [NB*BW-1:0] t;
        for (int k = 0; k < NB; k++) t[k*BW +: BW] = beat(base, k);
        return t[VW-1:0];
    endfunction

    // Hold one beat until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [BW-1:0] d, input logic cn, input logic [CW-1:0] cnt,
                             input logic last);
        bit acc;
        acc = 1'b0;
        up_SubVector = d;
        up_CntNew    = cn;
        up_Cnt       = cnt;
        up_Last      = last;
        up_Valid     = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = up_Ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("beat_timeout", 0, 1);
        up_Valid  = 1'b0;
        up_CntNew = 1'b0;
        up_Last   = 1'b0;
    endtask

    task automatic send_vector(input logic [7:0] base, input logic [CW-1:0] cnt, input logic last,
                               input bit gap);
        for (int k = 0; k < NB; k++) begin
            send_beat(beat(base, k), k == NB - 1, cnt, last && (k == NB - 1));
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic expect_out(input string tag, input logic [VW-1:0] vec, input logic [CW-1:0] cnt,
                              input logic last, output cap_t c);
        for (int t = 0; t < 50 && cap_q.size() == 0; t++) @(posedge clk);
        #1;
        c.vec  = '0;
        c.cnt  = '0;
        c.last = 1'b0;
        c.cyc  = 0;
        if (cap_q.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            c = cap_q.pop_front();
            check_vec({tag, "_vec"}, c.vec, vec);
            check({tag, "_cnt"}, c.cnt, cnt);
            check({tag, "_last"}, c.last, last);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        cap_t c0;
        cap_t c1;
        logic [7:0] base5;

        rst          = 1'b1;
        up_SubVector = '0;
        up_Valid     = 1'b0;
        up_Cnt       = '0;
        up_CntNew    = 1'b0;
        up_Last      = 1'b0;
        dn_Ready     = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_up_ready", up_Ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("rst_dn_valid", dn_Valid, 0);
        check("rst_dn_cnt", dn_Cnt, 0);
        check("rst_dn_last", dn_Last, 0);
        check("rst_proto_err", dn_ProtoErr, 0);
        check_vec("rst_dn_vec", dn_Vector, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: all-ones vector, output one cycle after final beat
        dn_Ready = 1'b1;
        for (int k = 0; k < NB - 1; k++) send_beat({BW{1'b1}}, 1'b0, 10'd920, 1'b0);
        check("t1_valid_early", dn_Valid, 0);
        send_beat({BW{1'b1}}, 1'b1, 10'd920, 1'b0);
        check("t1_valid", dn_Valid, 1);
        check("t1_head_cnt", dn_Cnt, 920);
        expect_out("t1", {VW{1'b1}}, 10'd920, 1'b0, c0);

        // 2: gapped beats land in their own slots, final beat truncated
        send_vector(8'h00, 10'd5, 1'b0, 1'b1);
        expect_out("t2", pattern(8'h00), 10'd5, 1'b0, c0);
        check("t2_beat0", c0.vec[127:0], {16{8'h00}});
        check("t2_beat1", c0.vec[255:128], {16{8'h01}});
        check("t2_tail", c0.vec[919:896], 24'h070707);

        // 3: full FIFO stalls every beat; draining preserves order
        dn_Ready = 1'b0;
        send_vector(8'h10, 10'd101, 1'b0, 1'b0);
        send_vector(8'h20, 10'd102, 1'b0, 1'b0);
        up_SubVector = beat(8'h30, 0);
        up_Valid     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", up_Ready, 0);
            check("t3_head_cnt", dn_Cnt, 101);
            check("t3_head_valid", dn_Valid, 1);
        end
        @(posedge clk);
        #1;
        dn_Ready = 1'b1;
        send_vector(8'h30, 10'd103, 1'b0, 1'b0);
        expect_out("t3_a", pattern(8'h10), 10'd101, 1'b0, c0);
        expect_out("t3_b", pattern(8'h20), 10'd102, 1'b0, c0);
        expect_out("t3_c", pattern(8'h30), 10'd103, 1'b0, c0);

        // 4: back-to-back vectors, one every 8 cycles, Last on the second
        send_vector(8'h40, 10'd200, 1'b0, 1'b0);
        send_vector(8'h50, 10'd201, 1'b1, 1'b0);
        expect_out("t4_a", pattern(8'h40), 10'd200, 1'b0, c0);
        expect_out("t4_b", pattern(8'h50), 10'd201, 1'b1, c1);
        check("t4_spacing", 128'(c1.cyc - c0.cyc), 8);

        // 5: reset mid-vector empties FIFO and restarts framing
        dn_Ready = 1'b0;
        send_vector(8'h60, 10'd300, 1'b0, 1'b0);
        base5 = 8'h70;
        for (int k = 0; k < 5; k++) send_beat(beat(base5, k), 1'b0, 10'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_valid", dn_Valid, 0);
        check("t5_cnt", dn_Cnt, 0);
        check("t5_last", dn_Last, 0);
        dn_Ready = 1'b1;
        send_vector(8'h80, 10'd301, 1'b0, 1'b0);
        expect_out("t5", pattern(8'h80), 10'd301, 1'b0, c0);
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_extra", 128'(cap_q.size()), 0);

        // 6: early CntNew marker raises the sticky error when the checker is built
        check("t6_err_before", dn_ProtoErr, 0);
        for (int k = 0; k < NB; k++) begin
            send_beat(beat(8'h90, k), (k == 3) || (k == NB - 1), 10'd400, 1'b0);
            if (k == 2) check("t6_err_beat2", dn_ProtoErr, 0);
            if (k == 3) check("t6_err_beat3", dn_ProtoErr, PROTO_EN);
        end
        expect_out("t6", pattern(8'h90), 10'd400, 1'b0, c0);
        check("t6_err_held", dn_ProtoErr, PROTO_EN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
